mmio_interconnect: RTL and testbench
====================================

// Module: mmio_interconnect
// PURPOSE
//  Parametrised memory-mapped data-bus interconnect between the RS5 data port and N_TGT targets (RAM, RTC, PLIC, TB regs).
//  Decodes the address into regions and muxes registered read data back to the core.
//  Adds per-target read wait states via ready/stall, plus capture of accesses to unmapped addresses.
// PARAMETERS
//  N_TGT       4                              number of targets (1..8)
//  DATA_W      32                             data width; byte-enable width DATA_W/8
//  SEL_MSB     31                             msb of the address region-select field
//  SEL_LSB     28                             lsb of the address region-select field
//  TGT_LIMIT   {4'hF,4'h8,4'h3,4'h2}          per-target exclusive upper bound of the select field; entry 0 is the lsb entry; ascending
//  FAULT_DATA  32'hDEAD_BEEF                  read data returned for an unmapped read
// PORTS
//  clk            in   1               clock
//  reset          in   1               synchronous reset, active-high
//  en_i           in   1               core access request (mem_operation_enable)
//  we_i           in   DATA_W/8        byte write enables; '0 = read
//  addr_i         in   32              access address
//  rdata_o        out  DATA_W          read data to the core
//  stall_o        out  1               stall to the core while a read waits on its target
//  tgt_en_o       out  N_TGT           one-hot target enable
//  tgt_rdata_i    in   N_TGT*DATA_W    target read data; target i in slice i
//  tgt_ready_i    in   N_TGT           target read data valid (tie 1 for fixed 1-cycle targets)
//  fault_valid_o  out  1               sticky: an unmapped access was captured
//  fault_addr_o   out  32              address of the first captured fault
//  fault_we_o     out  1               first fault was a write
//  fault_cnt_o    out  8               saturating count of all unmapped accesses
//  clr_fault_i    in   1               clears fault_valid_o, fault_addr_o, fault_we_o, fault_cnt_o
//  fault_irq_o    out  1               fault interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Decode (combinational):
//   - sel = addr_i[SEL_MSB:SEL_LSB]; target i hit when TGT_LIMIT[i-1] <= sel < TGT_LIMIT[i] (lower bound 0 for i=0).
//   - sel >= TGT_LIMIT[N_TGT-1] is unmapped.
//   - tgt_en_o[i] = en_i & hit[i] & (state==IDLE).
//  FSM (mmio_state_t): IDLE, RESP, WAIT.
//   - IDLE: an accepted read to target i registers sel_r=i and goes to RESP.
//     - Writes are posted: complete in the issue cycle, state stays IDLE.
//     - Unmapped read: sets flt_r, goes to RESP.
//   - RESP (issue+1):
//     - tgt_ready_i[sel_r]=1 -> rdata_o=tgt_rdata_i[sel_r], stall_o=0, next IDLE; a new en_i this cycle is accepted as in IDLE.
//     - tgt_ready_i[sel_r]=0 -> stall_o=1, next WAIT.
//     - flt_r set -> rdata_o=FAULT_DATA, stall_o=0.
//   - WAIT: stall_o=~tgt_ready_i[sel_r]; tgt_en_o=0; en_i is ignored (it is the held, already-issued access).
//     - On ready: rdata_o=tgt_rdata_i[sel_r] in that cycle, stall_o=0, next IDLE.
//  rdata_o outside a read response = 0.
//  Latency: 1 cycle for ready targets, 1+k cycles for k not-ready cycles; no timeout.
//  Fault capture, on any unmapped en_i accepted in IDLE:
//   - fault_cnt_o increments, saturating at 8'hFF.
//   - If fault_valid_o=0: capture addr_i and we_i!=0, set fault_valid_o. Later faults do not overwrite the capture.
//   - clr_fault_i in the same cycle as a new fault: the new fault wins; valid=1, cnt=1, new address captured.
//  Reset: state=IDLE; all outputs 0 except rdata_o=0 and stall_o=0.
//   - Reset asserted during WAIT aborts the access; no response is given.
// CONFIGURATION
//  MMIO_FAULT_IRQ_EN defined: fault_irq_o = fault_valid_o, a level held until clr_fault_i.
//  MMIO_FAULT_IRQ_EN not defined: fault_irq_o tied 0; capture registers still operate.
// STRUCTURE
//  RS5_pkg: mmio_state_t enum {IDLE, RESP, WAIT}; localparam MMIO_FAULT_CNT_W=8.
//  Sub-module mmio_region_decode: combinational sel -> one-hot hit and unmapped flag, parametrised by N_TGT/TGT_LIMIT.
// TESTING (defaults, all tgt_ready_i=1 unless stated)
//  1. Read 0x0000_0100, tgt0 data 32'h1234_5678 -> tgt_en_o=4'b0001 at t, rdata_o=32'h1234_5678 at t+1, stall_o=0.
//  2. Write 0x8000_0000, we=4'hF -> tgt_en_o=4'b1000 for one cycle, no stall; back-to-back read 0x2000_0000 next cycle -> tgt_en_o=4'b0010.
//  3. Read 0x3000_0004 with tgt_ready_i[2]=0 for 3 cycles after issue -> stall_o=1 for 3 cycles, tgt_en_o=0 during WAIT, data on the first ready cycle.
//  4. Read 0xF000_0010 -> rdata_o=32'hDEAD_BEEF, fault_valid_o=1, fault_addr_o=32'hF000_0010, fault_we_o=0, fault_cnt_o=1.
//     A second write to 0xF000_0020 -> addr unchanged, cnt=2.
//  5. clr_fault_i coincident with a write to 0xF000_0040 -> valid=1, cnt=1, addr=32'hF000_0040.
//     With MMIO_FAULT_IRQ_EN undefined -> fault_irq_o stays 0.
//  6. Reset asserted in WAIT -> next cycle state IDLE, stall_o=0, fault regs 0; 300 fault writes -> fault_cnt_o=8'hFF.

Source files
------------

// File: rtl/mmio_interconnect_pkg.sv
// -----------------------------------------------------------------------------
// mmio_interconnect_pkg
// Purpose : shared types, constants and helpers for the MMIO data-bus
//           interconnect (FSM state encoding, fault counter width, saturating
//           increment).
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mmio_interconnect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        WAIT = 2'd2
    } mmio_state_t;

    localparam int MMIO_FAULT_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [MMIO_FAULT_CNT_W-1:0] sat_inc(input logic [MMIO_FAULT_CNT_W-1:0] v);
        if (v == {MMIO_FAULT_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + MMIO_FAULT_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/mmio_interconnect_if.sv
// -----------------------------------------------------------------------------
// mmio_interconnect_if
// Purpose : core-side data port of the MMIO interconnect.
// Signals : en_i    access request
//           we_i    byte write enables ('0 = read)
//           addr_i  access address
//           rdata_o read data back to the core
//           stall_o core stall while a read waits on its target
// Modports: master (core side), slave (interconnect side)
// -----------------------------------------------------------------------------
interface mmio_interconnect_if #(
    parameter int DATA_W = 32
) ();
    logic                  en_i;
    logic [DATA_W/8-1:0]   we_i;
    logic [31:0]           addr_i;
    logic [DATA_W-1:0]     rdata_o;
    logic                  stall_o;

    modport master (output en_i, output we_i, output addr_i, input rdata_o, input stall_o);
    modport slave  (input en_i, input we_i, input addr_i, output rdata_o, output stall_o);
endinterface

// File: rtl/mmio_interconnect_region_decode.sv
// -----------------------------------------------------------------------------
// mmio_region_decode
// Purpose : maps the address region-select field onto a one-hot target hit
//           vector and an unmapped flag. Target i owns the half-open range
//           [TGT_LIMIT[i-1], TGT_LIMIT[i]) with an implicit lower bound of 0
//           for target 0; limits must be ascending.
// Ports   : i_sel       region-select field of the address
//           o_hit       one-hot target hit
//           o_unmapped  select at or above the last limit
// -----------------------------------------------------------------------------
module mmio_region_decode
    import mmio_interconnect_pkg::*;
#(
    parameter int                         N_TGT     = 4,
    parameter int                         SEL_W     = 4,
    parameter logic [N_TGT*SEL_W-1:0]     TGT_LIMIT = {4'hF, 4'h8, 4'h3, 4'h2}
) (
    input  logic [SEL_W-1:0] i_sel,
    output logic [N_TGT-1:0] o_hit,
    output logic             o_unmapped
);

    // Range compare per target; each upper bound becomes the next lower bound
    always_comb begin
        logic [SEL_W-1:0] v_lo;
        logic [SEL_W-1:0] v_hi;
        v_lo  = '0;
        v_hi  = '0;
        o_hit = '0;
        for (int i = 0; i < N_TGT; i++) begin
            v_hi     = TGT_LIMIT[i*SEL_W +: SEL_W];
            o_hit[i] = (i_sel >= v_lo) && (i_sel < v_hi);
            v_lo     = v_hi;
        end
    end

    assign o_unmapped = (i_sel >= TGT_LIMIT[(N_TGT-1)*SEL_W +: SEL_W]);

endmodule

// File: rtl/mmio_interconnect.sv
// -----------------------------------------------------------------------------
// mmio_interconnect
// Purpose : memory-mapped data-bus interconnect between the core data port and
//           N_TGT targets. Decodes the address into regions, enables the hit
//           target, returns its read data one cycle after issue (longer while
//           the target is not ready, stalling the core), posts writes, and
//           captures accesses to unmapped addresses.
// Ports   : clk, reset       clock, synchronous active-high reset
//           bus (slave)      core request / response (en, we, addr, rdata, stall)
//           tgt_en_o         one-hot target enable
//           tgt_rdata_i      target read data, target i in slice i
//           tgt_ready_i      target read data valid
//           fault_valid_o    sticky unmapped-access capture flag
//           fault_addr_o     address of the first captured fault
//           fault_we_o       first captured fault was a write
//           fault_cnt_o      saturating count of unmapped accesses
//           clr_fault_i      clears the capture registers
//           fault_irq_o      fault interrupt
// Config  : MMIO_FAULT_IRQ_EN defined -> fault_irq_o follows fault_valid_o;
//           otherwise fault_irq_o is tied low.
// -----------------------------------------------------------------------------
module mmio_interconnect
    import mmio_interconnect_pkg::*;
#(
    parameter int                                   N_TGT      = 4,
    parameter int                                   DATA_W     = 32,
    parameter int                                   SEL_MSB    = 31,
    parameter int                                   SEL_LSB    = 28,
    parameter logic [N_TGT*(SEL_MSB-SEL_LSB+1)-1:0] TGT_LIMIT  = {4'hF, 4'h8, 4'h3, 4'h2},
    parameter logic [DATA_W-1:0]                    FAULT_DATA = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        reset,
    mmio_interconnect_if.slave          bus,
    output logic [N_TGT-1:0]            tgt_en_o,
    input  logic [N_TGT*DATA_W-1:0]     tgt_rdata_i,
    input  logic [N_TGT-1:0]            tgt_ready_i,
    output logic                        fault_valid_o,
    output logic [31:0]                 fault_addr_o,
    output logic                        fault_we_o,
    output logic [MMIO_FAULT_CNT_W-1:0] fault_cnt_o,
    input  logic                        clr_fault_i,
    output logic                        fault_irq_o
);

    localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
    localparam int IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    mmio_state_t                 r_state;
    mmio_state_t                 w_state_next;
    logic [IDX_W-1:0]            r_sel;
    logic                        r_flt;
    logic                        r_fault_valid;
    logic [31:0]                 r_fault_addr;
    logic                        r_fault_we;
    logic [MMIO_FAULT_CNT_W-1:0] r_fault_cnt;

    logic [SEL_W-1:0]            w_sel;
    logic [N_TGT-1:0]            w_hit;
    logic                        w_unmapped;
    logic [IDX_W-1:0]            w_hit_idx;
    logic                        w_can_accept;
    logic                        w_accept;
    logic                        w_is_read;
    logic                        w_fault_evt;
    logic                        w_tgt_ready;
    logic [DATA_W-1:0]           w_tgt_rdata;
    logic [DATA_W-1:0]           w_rdata;
    logic                        w_stall;

    assign w_sel = bus.addr_i[SEL_MSB:SEL_LSB];

    mmio_region_decode #(
        .N_TGT     (N_TGT),
        .SEL_W     (SEL_W),
        .TGT_LIMIT (TGT_LIMIT)
    ) u_decode (
        .i_sel      (w_sel),
        .o_hit      (w_hit),
        .o_unmapped (w_unmapped)
    );

    // One-hot to index; hits are one-hot so OR-ing the candidates is exact
    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < N_TGT; i++) begin
            w_hit_idx = w_hit_idx | (w_hit[i] ? IDX_W'(i) : '0);
        end
    end

    assign w_tgt_ready = tgt_ready_i[r_sel];
    assign w_tgt_rdata = tgt_rdata_i[r_sel*DATA_W +: DATA_W];
    assign w_is_read   = (bus.we_i == '0);
    assign w_accept    = bus.en_i & w_can_accept;
    assign w_fault_evt = w_accept & w_unmapped;

    // Next-state and core-facing response; a completed response frees the
    // port in the same cycle, while a stalled RESP or any WAIT cycle holds it
    always_comb begin
        w_state_next = r_state;
        w_can_accept = 1'b0;
        w_rdata      = '0;
        w_stall      = 1'b0;
        if (reset) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_can_accept = 1'b1;
                end
                RESP: begin
                    if (r_flt) begin
                        w_rdata      = FAULT_DATA;
                        w_can_accept = 1'b1;
                        w_state_next = IDLE;
                    end else if (w_tgt_ready) begin
                        w_rdata      = w_tgt_rdata;
                        w_can_accept = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (w_tgt_ready) begin
                        w_rdata      = w_tgt_rdata;
                        w_state_next = IDLE;
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = WAIT;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
            if (w_accept && w_is_read) begin
                w_state_next = RESP;
            end else begin
                w_state_next = w_state_next;
            end
        end
    end

    // FSM state plus the target index / fault flag of the outstanding read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_flt   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && w_is_read) begin
                r_sel <= w_hit_idx;
                r_flt <= w_unmapped;
            end else begin
                r_sel <= r_sel;
                r_flt <= r_flt;
            end
        end
    end

    // Fault capture: first fault is kept; a fault coincident with a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= 32'h0000_0000;
            r_fault_we    <= 1'b0;
            r_fault_cnt   <= '0;
        end else if (w_fault_evt) begin
            r_fault_cnt <= clr_fault_i ? MMIO_FAULT_CNT_W'(1) : sat_inc(r_fault_cnt);
            if (clr_fault_i || !r_fault_valid) begin
                r_fault_valid <= 1'b1;
                r_fault_addr  <= bus.addr_i;
                r_fault_we    <= ~w_is_read;
            end else begin
                r_fault_valid <= r_fault_valid;
                r_fault_addr  <= r_fault_addr;
                r_fault_we    <= r_fault_we;
            end
        end else if (clr_fault_i) begin
            r_fault_valid <= 1'b0;
            r_fault_addr  <= 32'h0000_0000;
            r_fault_we    <= 1'b0;
            r_fault_cnt   <= '0;
        end else begin
            r_fault_valid <= r_fault_valid;
            r_fault_addr  <= r_fault_addr;
            r_fault_we    <= r_fault_we;
            r_fault_cnt   <= r_fault_cnt;
        end
    end

    assign tgt_en_o      = w_accept ? w_hit : '0;
    assign bus.rdata_o   = w_rdata;
    assign bus.stall_o   = w_stall;
    assign fault_valid_o = r_fault_valid;
    assign fault_addr_o  = r_fault_addr;
    assign fault_we_o    = r_fault_we;
    assign fault_cnt_o   = r_fault_cnt;

`ifdef MMIO_FAULT_IRQ_EN
    assign fault_irq_o = r_fault_valid;
`else
    assign fault_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_interconnect.sv
// -----------------------------------------------------------------------------
// tb_mmio_interconnect
// Self-checking bench for mmio_interconnect: directed scenarios plus a
// randomized transaction stream checked against a transaction-level model
// (region table lookup, latency from the wait count, fault capture rules).
// -----------------------------------------------------------------------------
module tb_mmio_interconnect;
    import mmio_interconnect_pkg::*;

    localparam int          N_TGT  = 4;
    localparam int          DATA_W = 32;
    localparam logic [31:0] FAULT  = 32'hDEAD_BEEF;
`ifdef MMIO_FAULT_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic                    clk;
    logic                    reset;
    logic [N_TGT-1:0]        tgt_en;
    logic [N_TGT*DATA_W-1:0] tgt_rdata;
    logic [N_TGT-1:0]        tgt_ready;
    logic                    fault_valid;
    logic [31:0]             fault_addr;
    logic                    fault_we;
    logic [7:0]              fault_cnt;
    logic                    clr_fault;
    logic                    fault_irq;

    int tests;
    int fails;

    // Region table: exclusive upper bound of the select field, target 0 first
    int limits [N_TGT] = '{2, 3, 8, 15};

    // Fault model
    bit          m_fvalid;
    logic [31:0] m_faddr;
    bit          m_fwe;
    int          m_fcnt;

    mmio_interconnect_if #(.DATA_W(DATA_W)) bus ();

    mmio_interconnect dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .tgt_en_o      (tgt_en),
        .tgt_rdata_i   (tgt_rdata),
        .tgt_ready_i   (tgt_ready),
        .fault_valid_o (fault_valid),
        .fault_addr_o  (fault_addr),
        .fault_we_o    (fault_we),
        .fault_cnt_o   (fault_cnt),
        .clr_fault_i   (clr_fault),
        .fault_irq_o   (fault_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_target(input logic [31:0] a);
        int s;
        s = int'(a[31:28]);
        for (int i = 0; i < N_TGT; i++) begin
            if (s < limits[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_fvalid = 1'b0; m_faddr = 32'h0; m_fwe = 1'b0; m_fcnt = 0;
    endtask

    task automatic model_access(input bit unm, input logic [31:0] a, input bit w, input bit clr);
        if (unm) begin
            if (clr || !m_fvalid) begin
                m_fvalid = 1'b1; m_faddr = a; m_fwe = w;
            end
            m_fcnt = clr ? 1 : ((m_fcnt < 255) ? m_fcnt + 1 : 255);
        end else if (clr) begin
            model_clear();
        end
    endtask

    // Apply one cycle of inputs at the falling edge, let outputs settle
    task automatic drive(input bit rst, input bit en, input logic [3:0] we, input logic [31:0] a,
                         input logic [3:0] rdy, input bit clr, input logic [127:0] d);
        @(negedge clk);
        reset       = rst;
        bus.en_i    = en;
        bus.we_i    = we;
        bus.addr_i  = a;
        tgt_ready   = rdy;
        clr_fault   = clr;
        tgt_rdata   = d;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b0000) begin fails++; $display("FAIL rst_tgt_en got %b want 0000", tgt_en); end
        tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", bus.rdata_o); end
        tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL rst_stall got %b want 0", bus.stall_o); end
        tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt, fault_irq} !== 42'h0) begin
            fails++; $display("FAIL rst_fault got v=%b a=%h w=%b c=%0d irq=%b want all 0",
                              fault_valid, fault_addr, fault_we, fault_cnt, fault_irq);
        end
    endtask

    task automatic test_read_basic();
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0100, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b0001) begin fails++; $display("FAIL rd_tgt_en got %b want 0001", tgt_en); end
        tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL rd_issue_rdata got %h want 0", bus.rdata_o); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, {96'h0, 32'h1234_5678});
        tests++; if (bus.rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL rd_data got %h want 12345678", bus.rdata_o); end
        tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL rd_stall got %b want 0", bus.stall_o); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, {96'h0, 32'h1234_5678});
        tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL rd_after got %h want 0", bus.rdata_o); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 4'hF, 32'h8000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b1000) begin fails++; $display("FAIL b2b_wr_en got %b want 1000", tgt_en); end
        tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL b2b_wr_stall got %b want 0", bus.stall_o); end
        drive(1'b0, 1'b1, 4'h0, 32'h2000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b0010) begin fails++; $display("FAIL b2b_rd_en got %b want 0010", tgt_en); end
        tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL b2b_wr_rdata got %h want 0", bus.rdata_o); end
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0010, 4'hF, 1'b0, {64'h0, 32'hAAAA_0001, 32'hBBBB_0000});
        tests++; if (tgt_en !== 4'b0001) begin fails++; $display("FAIL b2b_resp_accept got %b want 0001", tgt_en); end
        tests++; if (bus.rdata_o !== 32'hAAAA_0001) begin fails++; $display("FAIL b2b_rd1 got %h want aaaa0001", bus.rdata_o); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, {64'h0, 32'hAAAA_0001, 32'hBBBB_0000});
        tests++; if (bus.rdata_o !== 32'hBBBB_0000) begin fails++; $display("FAIL b2b_rd2 got %h want bbbb0000", bus.rdata_o); end
    endtask

    task automatic test_wait_states();
        drive(1'b0, 1'b1, 4'h0, 32'h3000_0004, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b0100) begin fails++; $display("FAIL ws_en got %b want 0100", tgt_en); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 4'h0, 32'h3000_0004, 4'b1011, 1'b0, {32'h0, 32'hC0DE_0003, 64'h0});
            tests++; if (bus.stall_o !== 1'b1) begin fails++; $display("FAIL ws_stall c=%0d got %b want 1", c, bus.stall_o); end
            tests++; if (tgt_en !== 4'b0000) begin fails++; $display("FAIL ws_tgt_en c=%0d got %b want 0000", c, tgt_en); end
        end
        drive(1'b0, 1'b1, 4'h0, 32'h3000_0004, 4'hF, 1'b0, {32'h0, 32'hC0DE_0003, 64'h0});
        tests++; if (bus.rdata_o !== 32'hC0DE_0003) begin fails++; $display("FAIL ws_data got %h want c0de0003", bus.rdata_o); end
        tests++; if ({bus.stall_o, tgt_en} !== 5'b0) begin fails++; $display("FAIL ws_done got stall=%b en=%b want 0/0000", bus.stall_o, tgt_en); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if (bus.rdata_o !== 32'h0) begin fails++; $display("FAIL ws_after got %h want 0", bus.rdata_o); end
    endtask

    task automatic test_fault();
        drive(1'b0, 1'b1, 4'h0, 32'hF000_0010, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b0000) begin fails++; $display("FAIL flt_en got %b want 0000", tgt_en); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if (bus.rdata_o !== FAULT) begin fails++; $display("FAIL flt_rdata got %h want deadbeef", bus.rdata_o); end
        tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt} !== {1'b1, 32'hF000_0010, 1'b0, 8'd1}) begin
            fails++; $display("FAIL flt_first got v=%b a=%h w=%b c=%0d want 1 f0000010 0 1", fault_valid, fault_addr, fault_we, fault_cnt);
        end
        tests++; if (fault_irq !== IRQ_EN) begin fails++; $display("FAIL flt_irq got %b want %b", fault_irq, IRQ_EN); end
        drive(1'b0, 1'b1, 4'h3, 32'hF000_0020, 4'hF, 1'b0, 128'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if ({fault_addr, fault_we, fault_cnt} !== {32'hF000_0010, 1'b0, 8'd2}) begin
            fails++; $display("FAIL flt_second got a=%h w=%b c=%0d want f0000010 0 2", fault_addr, fault_we, fault_cnt);
        end
        drive(1'b0, 1'b1, 4'hF, 32'hF000_0040, 4'hF, 1'b1, 128'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt} !== {1'b1, 32'hF000_0040, 1'b1, 8'd1}) begin
            fails++; $display("FAIL flt_clr_wins got v=%b a=%h w=%b c=%0d want 1 f0000040 1 1", fault_valid, fault_addr, fault_we, fault_cnt);
        end
        tests++; if (fault_irq !== IRQ_EN) begin fails++; $display("FAIL flt_irq2 got %b want %b", fault_irq, IRQ_EN); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b1, 128'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt, fault_irq} !== 42'h0) begin
            fails++; $display("FAIL flt_clear got v=%b a=%h w=%b c=%0d irq=%b want all 0", fault_valid, fault_addr, fault_we, fault_cnt, fault_irq);
        end
    endtask

    task automatic test_reset_in_wait();
        drive(1'b0, 1'b1, 4'hF, 32'hF000_0000, 4'hF, 1'b0, 128'h0);
        drive(1'b0, 1'b1, 4'h0, 32'h3000_0000, 4'hF, 1'b0, 128'h0);
        drive(1'b0, 1'b1, 4'h0, 32'h3000_0000, 4'b1011, 1'b0, 128'h0);
        drive(1'b0, 1'b1, 4'h0, 32'h3000_0000, 4'b1011, 1'b0, 128'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h0000_0000, 4'b1011, 1'b0, 128'h0);
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, {32'h0, 32'h5555_AAAA, 64'h0});
        tests++; if ({bus.stall_o, bus.rdata_o} !== 33'h0) begin
            fails++; $display("FAIL rw_abort got stall=%b rdata=%h want 0/0", bus.stall_o, bus.rdata_o);
        end
        tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt} !== 41'h0) begin
            fails++; $display("FAIL rw_fault_rst got v=%b a=%h w=%b c=%0d want all 0", fault_valid, fault_addr, fault_we, fault_cnt);
        end
        drive(1'b0, 1'b1, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if (tgt_en !== 4'b0001) begin fails++; $display("FAIL rw_idle_accept got %b want 0001", tgt_en); end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b1, 4'h1, 32'hF000_0000 + 32'(i * 4), 4'hF, 1'b0, 128'h0);
        end
        drive(1'b0, 1'b0, 4'h0, 32'h0000_0000, 4'hF, 1'b0, 128'h0);
        tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt} !== {1'b1, 32'hF000_0000, 1'b1, 8'hFF}) begin
            fails++; $display("FAIL rw_sat got v=%b a=%h w=%b c=%0d want 1 f0000000 1 255", fault_valid, fault_addr, fault_we, fault_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0]  a;
        logic [3:0]   w;
        logic [3:0]   rdy;
        logic [3:0]   exp_en;
        logic [31:0]  exp_rd;
        logic [127:0] d;
        int           t;
        int           k;
        int           pend_tgt;
        bit           pend;
        bit           clr;
        drive(1'b1, 1'b0, 4'h0, 32'h0, 4'hF, 1'b0, 128'h0);
        model_clear();
        pend = 1'b0; pend_tgt = 0;
        for (int n = 0; n < 250; n++) begin
            a   = $urandom;
            w   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            t   = ref_target(a);
            k   = $urandom_range(0, 3);
            clr = ($urandom_range(0, 11) == 0);
            d   = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b0, 1'b1, w, a, 4'hF, clr, d);
            exp_en = (t < 0) ? 4'b0000 : (4'b0001 << t);
            exp_rd = !pend ? 32'h0 : ((pend_tgt < 0) ? FAULT : d[pend_tgt*32 +: 32]);
            tests++; if (tgt_en !== exp_en) begin fails++; $display("FAIL rnd_en n=%0d a=%h got %b want %b", n, a, tgt_en, exp_en); end
            tests++; if (bus.rdata_o !== exp_rd) begin fails++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, bus.rdata_o, exp_rd); end
            tests++; if (bus.stall_o !== 1'b0) begin fails++; $display("FAIL rnd_stall n=%0d got %b want 0", n, bus.stall_o); end
            tests++; if ({fault_valid, fault_addr, fault_we, fault_cnt, fault_irq} !==
                         {m_fvalid, m_faddr, m_fwe, 8'(m_fcnt), IRQ_EN & m_fvalid}) begin
                fails++; $display("FAIL rnd_fault n=%0d got v=%b a=%h w=%b c=%0d want v=%b a=%h w=%b c=%0d",
                                  n, fault_valid, fault_addr, fault_we, fault_cnt, m_fvalid, m_faddr, m_fwe, m_fcnt);
            end
            model_access(t < 0, a, w != 4'h0, clr);
            pend = 1'b0;
            if (w == 4'h0) begin
                if (t >= 0 && k > 0) begin
                    for (int j = 0; j < k; j++) begin
                        rdy = 4'($urandom) & ~(4'b0001 << t);
                        d   = {$urandom, $urandom, $urandom, $urandom};
                        drive(1'b0, 1'b1, w, a, rdy, 1'b0, d);
                        tests++; if ({bus.stall_o, tgt_en, bus.rdata_o} !== {1'b1, 4'b0000, 32'h0}) begin
                            fails++; $display("FAIL rnd_wait n=%0d j=%0d got stall=%b en=%b rd=%h want 1/0000/0", n, j, bus.stall_o, tgt_en, bus.rdata_o);
                        end
                    end
                    rdy = 4'($urandom) | (4'b0001 << t);
                    d   = {$urandom, $urandom, $urandom, $urandom};
                    drive(1'b0, 1'b1, w, a, rdy, 1'b0, d);
                    tests++; if ({bus.stall_o, tgt_en, bus.rdata_o} !== {1'b0, 4'b0000, d[t*32 +: 32]}) begin
                        fails++; $display("FAIL rnd_late n=%0d got stall=%b en=%b rd=%h want 0/0000/%h", n, bus.stall_o, tgt_en, bus.rdata_o, d[t*32 +: 32]);
                    end
                end else begin
                    pend = 1'b1; pend_tgt = t;
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                drive(1'b0, 1'b0, 4'h0, $urandom, 4'hF, 1'b0, d);
                exp_rd = !pend ? 32'h0 : ((pend_tgt < 0) ? FAULT : d[pend_tgt*32 +: 32]);
                tests++; if ({bus.stall_o, tgt_en, bus.rdata_o} !== {1'b0, 4'b0000, exp_rd}) begin
                    fails++; $display("FAIL rnd_idle n=%0d got stall=%b en=%b rd=%h want 0/0000/%h", n, bus.stall_o, tgt_en, bus.rdata_o, exp_rd);
                end
                pend = 1'b0;
            end
        end
        d = {$urandom, $urandom, $urandom, $urandom};
        drive(1'b0, 1'b0, 4'h0, 32'h0, 4'hF, 1'b0, d);
        exp_rd = !pend ? 32'h0 : ((pend_tgt < 0) ? FAULT : d[pend_tgt*32 +: 32]);
        tests++; if (bus.rdata_o !== exp_rd) begin fails++; $display("FAIL rnd_flush got %h want %h", bus.rdata_o, exp_rd); end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; bus.en_i = 1'b0; bus.we_i = 4'h0; bus.addr_i = 32'h0;
        tgt_ready = 4'hF; tgt_rdata = '0; clr_fault = 1'b0;
        model_clear();
        test_reset();
        test_read_basic();
        test_back_to_back();
        test_wait_states();
        test_fault();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
